// File: rtl/regwb_pkg.sv
// regwb_pkg: definitions shared by the register-file writeback arbiter.
//   XLEN / AW : default register data width and register index width.
//   req_e     : identifies a writeback requester (ALU/execute or load unit).
//   wb_req_t  : a writeback request, destination index plus data.
package regwb_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/regwb_scoreboard.sv
// regwb_scoreboard: per-register pending-load tracker and decode hazard check.
//   clk, reset     : clock and synchronous active-high reset (clears all bits).
//   set_en, set_rd : a load is issued this cycle toward set_rd.
//   clr_en, clr_rd : a load writeback to clr_rd is granted this cycle.
//   rs1, rs2       : decode source registers.
//   hazard         : a source register is waiting on an outstanding load.
// Register 0 is never tracked; its bit is tied to 0.
module regwb_scoreboard #(
  parameter int AW = regwb_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_rd,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          hazard
);
  import regwb_pkg::*;

  localparam int NREG = 1 << AW;

  logic [NREG-1:0] pending;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] visible;
  logic            issue_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign pending[gi]  = 1'b0;
        assign clr_mask[gi] = 1'b0;
      end else begin : g_bit
        logic pending_reg;
        logic set_hit;
        logic clr_hit;

        assign set_hit = set_en && (set_rd == AW'(gi));
        assign clr_hit = clr_en && (clr_rd == AW'(gi));

        // A new load to the same register outranks the completion of an
        // older one, so set is checked before clear.
        always_ff @(posedge clk) begin
          if (reset) begin
            pending_reg <= 1'b0;
          end else if (set_hit) begin
            pending_reg <= 1'b1;
          end else if (clr_hit) begin
            pending_reg <= 1'b0;
          end
        end

        assign pending[gi]  = pending_reg;
        assign clr_mask[gi] = clr_hit;
      end
    end
  endgenerate

  // The bit being cleared by this cycle's grant is already treated as done,
  // so decode is released in the grant cycle itself.
  assign visible = pending & ~clr_mask;

  // A load issued this cycle blocks its destination immediately, before its
  // pending bit is even written.
  assign issue_hit = set_en && (set_rd != '0) &&
                     ((set_rd == rs1) || (set_rd == rs2));

  assign hazard = visible[rs1] | visible[rs2] | issue_hit;

endmodule

// File: rtl/regwb_arbiter.sv
// regwb_arbiter: owns the single register-file write port and shares it
// between ALU writeback and load writeback with round-robin arbitration.
// Also tracks outstanding loads and raises a read hazard for decode.
//   clk, reset              : clock, synchronous active-high reset.
//   alu_valid/rd/dat, ready : ALU writeback request and same-cycle grant.
//   mem_valid/rd/dat, ready : load writeback request and same-cycle grant.
//   ld_issue, ld_issue_rd   : load issued this cycle and its destination.
//   rs1, rs2, hazard        : decode sources and stall request.
//   rf_we, rf_rd, rf_dat    : registered register-file write port.
// Optional build macro REGWB_BYPASS_EN adds fwd1_valid/fwd1_dat and
// fwd2_valid/fwd2_dat, which expose the in-flight write to decode when it
// targets rs1/rs2.
module regwb_arbiter #(
  parameter int XLEN = regwb_pkg::XLEN,
  parameter int AW   = regwb_pkg::AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_dat,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_dat,
  output logic            mem_ready,
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_issue_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            hazard,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_dat
`ifdef REGWB_BYPASS_EN
  ,
  output logic            fwd1_valid,
  output logic [XLEN-1:0] fwd1_dat,
  output logic            fwd2_valid,
  output logic [XLEN-1:0] fwd2_dat
`endif
);
  import regwb_pkg::*;

  req_e            last_grant_reg;
  logic            alu_grant;
  logic            mem_grant;
  logic            any_grant;
  logic [AW-1:0]   grant_rd;
  logic [XLEN-1:0] grant_dat;
  logic            rf_we_reg;
  logic [AW-1:0]   rf_rd_reg;
  logic [XLEN-1:0] rf_dat_reg;

  // Round-robin: a lone requester always wins; on contention the one that
  // did not win most recently is granted.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (alu_valid && mem_valid) begin
      if (last_grant_reg == REQ_MEM) begin
        alu_grant = 1'b1;
      end else begin
        mem_grant = 1'b1;
      end
    end else begin
      alu_grant = alu_valid;
      mem_grant = mem_valid;
    end
  end

  assign any_grant = alu_grant | mem_grant;
  assign grant_rd  = mem_grant ? mem_rd  : alu_rd;
  assign grant_dat = mem_grant ? mem_dat : alu_dat;
  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;

  // Write stage. A grant to x0 still uses the slot but never writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= REQ_MEM;
      rf_we_reg      <= 1'b0;
      rf_rd_reg      <= '0;
      rf_dat_reg     <= '0;
    end else begin
      rf_we_reg <= any_grant && (grant_rd != '0);
      if (any_grant) begin
        rf_rd_reg      <= grant_rd;
        rf_dat_reg     <= grant_dat;
        last_grant_reg <= mem_grant ? REQ_MEM : REQ_ALU;
      end
    end
  end

  assign rf_we  = rf_we_reg;
  assign rf_rd  = rf_rd_reg;
  assign rf_dat = rf_dat_reg;

  regwb_scoreboard #(
    .AW(AW)
  ) u_scoreboard (
    .clk    (clk),
    .reset  (reset),
    .set_en (ld_issue),
    .set_rd (ld_issue_rd),
    .clr_en (mem_grant),
    .clr_rd (mem_rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .hazard (hazard)
  );

`ifdef REGWB_BYPASS_EN
  assign fwd1_valid = rf_we_reg && (rf_rd_reg != '0) && (rf_rd_reg == rs1);
  assign fwd1_dat   = rf_dat_reg;
  assign fwd2_valid = rf_we_reg && (rf_rd_reg != '0) && (rf_rd_reg == rs2);
  assign fwd2_dat   = rf_dat_reg;
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// tb_regwb_arbiter: self-checking bench for regwb_arbiter.
// Inputs change on the falling edge; combinational outputs are checked just
// after, and the registered write port is checked against a queue of
// expected writes on the following falling edge.
module tb_regwb_arbiter;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] dat;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_dat;
  logic            alu_ready;
  logic            mem_valid;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_dat;
  logic            mem_ready;
  logic            ld_issue;
  logic [AW-1:0]   ld_issue_rd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            hazard;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_dat;
`ifdef REGWB_BYPASS_EN
  logic            fwd1_valid;
  logic [XLEN-1:0] fwd1_dat;
  logic            fwd2_valid;
  logic [XLEN-1:0] fwd2_dat;
`endif

  int              n_checks;
  int              n_fail;
  exp_t            exp_q[$];
  exp_t            mon_e;
  logic            m_last_mem;
  logic [AW-1:0]   m_rd;
  logic [XLEN-1:0] m_dat;

  regwb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_dat     (alu_dat),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_dat     (mem_dat),
    .mem_ready   (mem_ready),
    .ld_issue    (ld_issue),
    .ld_issue_rd (ld_issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .hazard      (hazard),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_dat      (rf_dat)
`ifdef REGWB_BYPASS_EN
    ,
    .fwd1_valid  (fwd1_valid),
    .fwd1_dat    (fwd1_dat),
    .fwd2_valid  (fwd2_valid),
    .fwd2_dat    (fwd2_dat)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference for the write port: computes what the next cycle's rf outputs
  // must be from the inputs currently driven, and queues it.
  task automatic predict();
    exp_t e;
    logic g_alu;
    logic g_mem;
    g_alu = alu_valid && (!mem_valid || m_last_mem);
    g_mem = mem_valid && !g_alu;
    e.we  = 1'b0;
    e.rd  = m_rd;
    e.dat = m_dat;
    if (reset) begin
      e = '0;
      m_last_mem = 1'b1;
    end else if (g_alu) begin
      e.we = (alu_rd != 0);
      e.rd = alu_rd;
      e.dat = alu_dat;
      m_last_mem = 1'b0;
    end else if (g_mem) begin
      e.we = (mem_rd != 0);
      e.rd = mem_rd;
      e.dat = mem_dat;
      m_last_mem = 1'b1;
    end
    m_rd  = e.rd;
    m_dat = e.dat;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic r,
                     input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] adat,
                     input logic mv, input logic [AW-1:0] mrd, input logic [XLEN-1:0] mdat,
                     input logic li, input logic [AW-1:0] lird,
                     input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    @(negedge clk);
    reset = r;
    alu_valid = av; alu_rd = ard; alu_dat = adat;
    mem_valid = mv; mem_rd = mrd; mem_dat = mdat;
    ld_issue = li; ld_issue_rd = lird;
    rs1 = r1; rs2 = r2;
    #1;
    predict();
  endtask

  // Scoreboard drain: one registered write per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if ({rf_we, rf_rd, rf_dat} !== {mon_e.we, mon_e.rd, mon_e.dat}) begin
        n_fail++;
        $display("FAIL rf_write: got we=%0b rd=%0d dat=%h, expected we=%0b rd=%0d dat=%h",
                 rf_we, rf_rd, rf_dat, mon_e.we, mon_e.rd, mon_e.dat);
      end
    end
  end

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
    n_checks++;
    if ({rf_we, rf_rd, rf_dat} !== '0) begin
      n_fail++; $display("FAIL reset_rf: got we=%0b rd=%0d dat=%h, expected all zero", rf_we, rf_rd, rf_dat);
    end
    n_checks++;
    if (hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %0b expected 0", hazard); end
    n_checks++;
    if ({alu_ready, mem_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got alu=%0b mem=%0b expected 0 0", alu_ready, mem_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_alu_write();
    cyc(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({alu_ready, mem_ready} !== 2'b10) begin
      n_fail++; $display("FAIL alu_grant: got alu=%0b mem=%0b expected 1 0", alu_ready, mem_ready);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({rf_we, rf_rd, rf_dat} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL alu_write: got we=%0b rd=%0d dat=%h, expected 1 5 deadbeef", rf_we, rf_rd, rf_dat);
    end
    $display("test_alu_write done");
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_rd_seq[3];
    logic          exp_alu;
    exp_rd_seq[0] = 5'd3; exp_rd_seq[1] = 5'd4; exp_rd_seq[2] = 5'd3;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 3, 32'h0000_3333, 1, 4, 32'h0000_4444, 0, 0, 0, 0);
      exp_alu = (i != 1);
      n_checks++;
      if ({alu_ready, mem_ready} !== {exp_alu, !exp_alu}) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got alu=%0b mem=%0b expected %0b %0b",
                           i, alu_ready, mem_ready, exp_alu, !exp_alu);
      end
      if (i > 0) begin
        n_checks++;
        if ({rf_we, rf_rd} !== {1'b1, exp_rd_seq[i-1]}) begin
          n_fail++; $display("FAIL rr_write[%0d]: got we=%0b rd=%0d expected 1 %0d", i, rf_we, rf_rd, exp_rd_seq[i-1]);
        end
      end
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({rf_we, rf_rd} !== {1'b1, exp_rd_seq[2]}) begin
      n_fail++; $display("FAIL rr_write[3]: got we=%0b rd=%0d expected 1 %0d", rf_we, rf_rd, exp_rd_seq[2]);
    end
    $display("test_round_robin done");
  endtask

  task automatic test_load_hazard();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    n_checks++;
    if (hazard !== 1'b1) begin n_fail++; $display("FAIL ld_issue_hazard: got %0b expected 1", hazard); end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
      n_checks++;
      if (hazard !== 1'b1) begin n_fail++; $display("FAIL pending_hazard[%0d]: got %0b expected 1", i, hazard); end
    end
    cyc(0, 0, 0, 0, 1, 7, 32'h7777_0007, 0, 0, 7, 0);
    n_checks++;
    if ({mem_ready, hazard} !== 2'b10) begin
      n_fail++; $display("FAIL grant_cycle_hazard: got ready=%0b hazard=%0b expected 1 0", mem_ready, hazard);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    n_checks++;
    if ({hazard, rf_we, rf_rd, rf_dat} !== {1'b0, 1'b1, 5'd7, 32'h7777_0007}) begin
      n_fail++; $display("FAIL load_write: got hazard=%0b we=%0b rd=%0d dat=%h expected 0 1 7 77770007",
                         hazard, rf_we, rf_rd, rf_dat);
    end
    $display("test_load_hazard done");
  endtask

  task automatic test_set_wins();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
    cyc(0, 0, 0, 0, 1, 9, 32'h0000_9999, 1, 9, 0, 9);
    n_checks++;
    if ({mem_ready, hazard} !== 2'b11) begin
      n_fail++; $display("FAIL set_clr_same: got ready=%0b hazard=%0b expected 1 1", mem_ready, hazard);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    n_checks++;
    if (hazard !== 1'b1) begin n_fail++; $display("FAIL set_wins_hold: got %0b expected 1", hazard); end
    cyc(0, 0, 0, 0, 1, 9, 32'h0000_009A, 0, 0, 0, 9);
    n_checks++;
    if (hazard !== 1'b0) begin n_fail++; $display("FAIL set_wins_release: got %0b expected 0", hazard); end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    n_checks++;
    if (hazard !== 1'b0) begin n_fail++; $display("FAIL set_wins_cleared: got %0b expected 0", hazard); end
    $display("test_set_wins done");
  endtask

  task automatic test_rd_zero();
    cyc(0, 1, 0, 32'h0000_1234, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_grant: got %0b expected 1", alu_ready); end
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    n_checks++;
    if ({rf_we, hazard} !== 2'b00) begin
      n_fail++; $display("FAIL rd0_write: got we=%0b hazard=%0b expected 0 0", rf_we, hazard);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (hazard !== 1'b0) begin n_fail++; $display("FAIL rd0_pending: got %0b expected 0", hazard); end
    $display("test_rd_zero done");
  endtask

  task automatic test_reset_mid();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 12, 12, 0);
    cyc(0, 1, 6, 32'h0000_0066, 0, 0, 0, 0, 0, 12, 0);
    n_checks++;
    if ({alu_ready, hazard} !== 2'b11) begin
      n_fail++; $display("FAIL pre_reset: got ready=%0b hazard=%0b expected 1 1", alu_ready, hazard);
    end
    cyc(1, 1, 6, 32'h0000_0066, 0, 0, 0, 0, 0, 12, 0);
    n_checks++;
    if ({rf_we, rf_rd} !== {1'b1, 5'd6}) begin
      n_fail++; $display("FAIL latched_write: got we=%0b rd=%0d expected 1 6", rf_we, rf_rd);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0);
    n_checks++;
    if ({rf_we, hazard} !== 2'b00) begin
      n_fail++; $display("FAIL mid_reset: got we=%0b hazard=%0b expected 0 0", rf_we, hazard);
    end
    cyc(0, 1, 1, 32'h0000_0011, 1, 2, 32'h0000_0022, 0, 0, 0, 0);
    n_checks++;
    if ({alu_ready, mem_ready} !== 2'b10) begin
      n_fail++; $display("FAIL post_reset_priority: got alu=%0b mem=%0b expected 1 0", alu_ready, mem_ready);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("test_reset_mid done");
  endtask

`ifdef REGWB_BYPASS_EN
  task automatic test_bypass();
    cyc(0, 1, 6, 32'h0000_00A5, 0, 0, 0, 0, 0, 6, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
    n_checks++;
    if ({fwd1_valid, fwd1_dat, fwd2_valid} !== {1'b1, 32'h0000_00A5, 1'b0}) begin
      n_fail++; $display("FAIL bypass_fwd: got v1=%0b d1=%h v2=%0b expected 1 000000a5 0",
                         fwd1_valid, fwd1_dat, fwd2_valid);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
    n_checks++;
    if (fwd1_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_idle: got %0b expected 0", fwd1_valid); end
    $display("test_bypass done");
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail = 0;
    m_last_mem = 1'b1;
    m_rd = '0;
    m_dat = '0;
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_dat = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_dat = '0;
    ld_issue = 1'b0; ld_issue_rd = '0;
    rs1 = '0; rs2 = '0;

    test_reset();
    test_alu_write();
    test_round_robin();
    test_load_hazard();
    test_set_wins();
    test_rd_zero();
    test_reset_mid();
`ifdef REGWB_BYPASS_EN
    test_bypass();
`endif

    @(negedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
